// File: rtl/dpram_param_pkg.sv
// Shared types for the parametrised dual-port RAM: clear-sequencer state
// encoding and the write-mode constants selected by WRITE_FIRST.
package dpram_param_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam bit WM_READ_FIRST  = 1'b0;
    localparam bit WM_WRITE_FIRST = 1'b1;

endpackage

// File: rtl/dpram_param_if.sv
// One RAM access port: request signals from the master, read data and
// read-valid back from the RAM.
interface dpram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
);
    // Handshake: en is a request that is taken in the cycle it is high unless
    // the RAM is busy clearing, in which case it is dropped (there is no
    // ready/stall). Every taken request, read or write, later raises rvalid
    // for exactly one cycle with q holding that request's read data.
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;
    logic              rvalid;

    modport master (output en, output we, output addr, output data,
                    input q, input rvalid);
    modport slave  (input en, input we, input addr, input data,
                    output q, output rvalid);
endinterface

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: walks every address once writing CLEAR_VAL, raising busy
// while it owns the array. Started by reset (optionally) or by clear_req.
module dpram_clear_seq
    import dpram_param_pkg::*;
#(
    parameter int                ADDR_W       = 11,
    parameter int                DATA_W       = 8,
    parameter bit                CLEAR_ON_RST = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data,
    output clr_state_t        state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // clear_req is deliberately not looked at here
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign clr_addr = cnt_q;
    assign clr_data = CLEAR_VAL;
    assign state    = state_q;

endmodule

// File: rtl/dpram_param.sv
// Parametrised true dual-port synchronous RAM with hardware clear, optional
// output register and per-port read-valid pipelines.
module dpram_param
    import dpram_param_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 11,
    parameter bit                OUT_REG      = 1'b0,
    parameter bit                WRITE_FIRST  = WM_WRITE_FIRST,
    parameter bit                CLEAR_ON_RST = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          busy,
    output clr_state_t    clr_state,
    dpram_param_if.slave  port_a,
    dpram_param_if.slave  port_b
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit WF    = (WRITE_FIRST == WM_WRITE_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    logic              acc_a, acc_b, user_wr_a, wr_a, wr_b;
    logic [ADDR_W-1:0] waddr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              rv1_a_d, rv1_a_q, rv1_b_d, rv1_b_q;
    logic [DATA_W-1:0] rd_a_q, rd_b_q;

    dpram_clear_seq #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .CLEAR_ON_RST (CLEAR_ON_RST),
        .CLEAR_VAL    (CLEAR_VAL)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .clr_data  (clr_data),
        .state     (clr_state)
    );

    // The clear sequencer borrows port A's write path; user traffic is
    // locked out entirely while it runs. On a same-address double write,
    // port A wins and port B's store is suppressed.
    always_comb begin
        acc_a     = port_a.en & ~busy & ~rst;
        acc_b     = port_b.en & ~busy & ~rst;
        user_wr_a = acc_a & port_a.we;
        wr_a      = clr_we | user_wr_a;
        waddr_a   = clr_we ? clr_addr : port_a.addr;
        wdata_a   = clr_we ? clr_data : port_a.data;
        wr_b      = acc_b & port_b.we & ~(user_wr_a & (port_a.addr == port_b.addr));
        rv1_a_d   = acc_a;
        rv1_b_d   = acc_b;
    end

    always_ff @(posedge clk) begin
        if (wr_a) mem[waddr_a] <= wdata_a;
        if (wr_b) mem[port_b.addr] <= port_b.data;
    end

    // Reads see pre-edge contents, so a cross-port reader gets the old word.
    // In write-first mode a port returns its own write data, even when its
    // store lost the same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a_q <= '0;
        end else if (acc_a) begin
            rd_a_q <= (WF && port_a.we) ? port_a.data : mem[port_a.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_b_q <= '0;
        end else if (acc_b) begin
            rd_b_q <= (WF && port_b.we) ? port_b.data : mem[port_b.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv1_a_q <= 1'b0;
            rv1_b_q <= 1'b0;
        end else begin
            rv1_a_q <= rv1_a_d;
            rv1_b_q <= rv1_b_d;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [DATA_W-1:0] q_a_d, q_a_q, q_b_d, q_b_q;
        logic              rv2_a_d, rv2_a_q, rv2_b_d, rv2_b_q;

        always_comb begin
            q_a_d   = rv1_a_q ? rd_a_q : q_a_q;
            q_b_d   = rv1_b_q ? rd_b_q : q_b_q;
            rv2_a_d = rv1_a_q;
            rv2_b_d = rv1_b_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q_a_q   <= '0;
                q_b_q   <= '0;
                rv2_a_q <= 1'b0;
                rv2_b_q <= 1'b0;
            end else begin
                q_a_q   <= q_a_d;
                q_b_q   <= q_b_d;
                rv2_a_q <= rv2_a_d;
                rv2_b_q <= rv2_b_d;
            end
        end

        assign port_a.q      = q_a_q;
        assign port_a.rvalid = rv2_a_q;
        assign port_b.q      = q_b_q;
        assign port_b.rvalid = rv2_b_q;
    end else begin : g_no_out_reg
        assign port_a.q      = rd_a_q;
        assign port_a.rvalid = rv1_a_q;
        assign port_b.q      = rd_b_q;
        assign port_b.rvalid = rv1_b_q;
    end

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: two instances (latency 1 write-first, latency 2
// read-first) driven with identical stimulus and checked against a queue.
module tb_dpram_param;
    import dpram_param_pkg::*;

    localparam int          DW    = 8;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [7:0]  CV    = 8'hA5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       clear_req = 1'b0;
    logic       busy0, busy1;
    clr_state_t st0, st1;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    dpram_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_a0 ();
    dpram_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_b0 ();
    dpram_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_a1 ();
    dpram_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_b1 ();

    dpram_param #(
        .DATA_W(DW), .ADDR_W(AW), .OUT_REG(1'b0), .WRITE_FIRST(1'b1),
        .CLEAR_ON_RST(1'b1), .CLEAR_VAL(CV)
    ) u_dut0 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy0),
        .clr_state(st0), .port_a(if_a0), .port_b(if_b0)
    );

    dpram_param #(
        .DATA_W(DW), .ADDR_W(AW), .OUT_REG(1'b1), .WRITE_FIRST(1'b0),
        .CLEAR_ON_RST(1'b1), .CLEAR_VAL(CV)
    ) u_dut1 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy1),
        .clr_state(st1), .port_a(if_a1), .port_b(if_b1)
    );

    // ---------------- scoreboard ----------------
    // Channels: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
    // Entry = {due cycle[15:0], data[7:0]}.
    logic [23:0] exp_q [4][$];
    logic [7:0]  last_exp [4];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          busy_run = 0;
    int          last_busy_len = 0;
    int          busy_done_cnt = 0;

    typedef struct {
        logic       clr;
        logic       en_a, we_a;
        logic [3:0] addr_a;
        logic [7:0] data_a;
        logic       en_b, we_b;
        logic [3:0] addr_b;
        logic [7:0] data_b;
        logic [7:0] ea_wf, ea_rf, eb_wf, eb_rf;
    } vec_t;

    function automatic vec_t mk(input logic en_a, input logic we_a, input logic [3:0] addr_a,
                                input logic [7:0] data_a, input logic en_b, input logic we_b,
                                input logic [3:0] addr_b, input logic [7:0] data_b,
                                input logic [7:0] ea_wf, input logic [7:0] ea_rf,
                                input logic [7:0] eb_wf, input logic [7:0] eb_rf);
        vec_t v;
        v.clr = 1'b0;
        v.en_a = en_a; v.we_a = we_a; v.addr_a = addr_a; v.data_a = data_a;
        v.en_b = en_b; v.we_b = we_b; v.addr_b = addr_b; v.data_b = data_b;
        v.ea_wf = ea_wf; v.ea_rf = ea_rf; v.eb_wf = eb_wf; v.eb_rf = eb_rf;
        return v;
    endfunction

    task automatic check_ch(input int ch, input logic rv, input logic [7:0] q);
        logic [23:0] e;
        if (rv === 1'b1) begin
            n_tests++;
            if (exp_q[ch].size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid ch%0d cyc=%0d: rvalid=1 q=%h, required rvalid=0", ch, cyc, q);
            end else begin
                e = exp_q[ch].pop_front();
                if (q !== e[7:0] || e[23:8] != 16'(cyc)) begin
                    n_fail++;
                    $display("FAIL rdata ch%0d: q=%h at cyc %0d, required q=%h at cyc %0d",
                             ch, q, cyc, e[7:0], e[23:8]);
                end
                last_exp[ch] = e[7:0];
            end
        end else begin
            if (exp_q[ch].size() > 0 && exp_q[ch][0][23:8] <= 16'(cyc)) begin
                n_tests++;
                n_fail++;
                e = exp_q[ch].pop_front();
                $display("FAIL missing_rvalid ch%0d cyc=%0d: rvalid=%b, required 1 with q=%h", ch, cyc, rv, e[7:0]);
            end
            n_tests++;
            if (rv !== 1'b0 || q !== last_exp[ch]) begin
                n_fail++;
                $display("FAIL hold ch%0d cyc=%0d: rvalid=%b q=%h, required rvalid=0 q=%h",
                         ch, cyc, rv, q, last_exp[ch]);
            end
        end
    endtask

    // Output monitor and busy run-length tracker, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) last_exp[c] = '0;
            busy_run = 0;
        end else begin
            check_ch(0, if_a0.rvalid, if_a0.q);
            check_ch(1, if_b0.rvalid, if_b0.q);
            check_ch(2, if_a1.rvalid, if_a1.q);
            check_ch(3, if_b1.rvalid, if_b1.q);
            if (busy0 === 1'b1) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_done_cnt++;
                busy_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input vec_t v);
        clear_req = v.clr;
        if_a0.en = v.en_a; if_a0.we = v.we_a; if_a0.addr = v.addr_a; if_a0.data = v.data_a;
        if_a1.en = v.en_a; if_a1.we = v.we_a; if_a1.addr = v.addr_a; if_a1.data = v.data_a;
        if_b0.en = v.en_b; if_b0.we = v.we_b; if_b0.addr = v.addr_b; if_b0.data = v.data_b;
        if_b1.en = v.en_b; if_b1.we = v.we_b; if_b1.addr = v.addr_b; if_b1.data = v.data_b;
    endtask

    task automatic drive(input vec_t v, input bit accept);
        @(posedge clk);
        #1;
        set_inputs(v);
        if (accept) begin
            if (v.en_a) begin
                exp_q[0].push_back({16'(cyc + 1), v.ea_wf});
                exp_q[2].push_back({16'(cyc + 2), v.ea_rf});
            end
            if (v.en_b) begin
                exp_q[1].push_back({16'(cyc + 1), v.eb_wf});
                exp_q[3].push_back({16'(cyc + 2), v.eb_rf});
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic do_reset(input int n);
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_inputs(idle);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_q_a0", if_a0.q, 8'h00);
        chk("rst_q_b0", if_b0.q, 8'h00);
        chk("rst_rv_a0", {7'd0, if_a0.rvalid}, 8'h00);
        chk("rst_rv_b0", {7'd0, if_b0.rvalid}, 8'h00);
        chk("rst_q_a1", if_a1.q, 8'h00);
        chk("rst_q_b1", if_b1.q, 8'h00);
        chk("rst_rv_a1", {7'd0, if_a1.rvalid}, 8'h00);
        chk("rst_rv_b1", {7'd0, if_b1.rvalid}, 8'h00);
        chk("rst_busy0", {7'd0, busy0}, 8'h01);
        chk("rst_busy1", {7'd0, busy1}, 8'h01);
    endtask

    task automatic wait_clear_done(input string name);
        int start;
        bit done;
        start = busy_done_cnt;
        done  = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #1;
            if (busy_done_cnt != start) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: busy still high after 100 cycles, required low after %0d", name, DEPTH);
        end else if (last_busy_len != DEPTH) begin
            n_fail++;
            $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, last_busy_len, DEPTH);
        end
    endtask

    task automatic sweep_clear_val();
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            drive(mk(1, 0, 4'(i), 0, 1, 0, 4'(DEPTH - 1 - i), 0, CV, CV, CV, CV), 1'b1);
        repeat (3) drive(idle, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    vec_t       tbl [10];
    logic [7:0] shadow [16];

    initial begin
        vec_t idle, clr;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr  = idle;
        clr.clr = 1'b1;
        set_inputs(idle);

        //                 en we addr data   en we addr data   a_wf   a_rf   b_wf   b_rf
        tbl[0] = mk(1, 1, 5, 8'h3C, 0, 0, 0, 8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00);
        tbl[1] = mk(0, 0, 0, 8'h00, 1, 0, 5, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C);
        tbl[2] = mk(1, 1, 7, 8'h01, 1, 1, 7, 8'h02, 8'h01, 8'hA5, 8'h02, 8'hA5);
        tbl[3] = mk(1, 0, 7, 8'h00, 1, 0, 7, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01);
        tbl[4] = mk(1, 1, 9, 8'hFF, 1, 0, 9, 8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5);
        tbl[5] = mk(1, 0, 9, 8'h00, 1, 0, 5, 8'h00, 8'hFF, 8'hFF, 8'h3C, 8'h3C);
        tbl[6] = mk(1, 0, 4, 8'h00, 1, 1, 4, 8'h66, 8'hA5, 8'hA5, 8'h66, 8'hA5);
        tbl[7] = mk(1, 0, 4, 8'h00, 1, 0, 4, 8'h00, 8'h66, 8'h66, 8'h66, 8'h66);
        tbl[8] = mk(1, 1, 8, 8'h88, 1, 1, 7, 8'h77, 8'h88, 8'hA5, 8'h77, 8'h01);
        tbl[9] = mk(1, 0, 7, 8'h00, 1, 0, 8, 8'h00, 8'h77, 8'h77, 8'h88, 8'h88);

        // 1: reset, automatic clear, dropped write late in the sequence
        do_reset(2);
        repeat (6) drive(idle, 1'b0);
        drive(mk(1, 1, 3, 8'h11, 1, 0, 3, 0, 0, 0, 0, 0), 1'b0);
        drive(idle, 1'b0);
        wait_clear_done("rst_clear");
        sweep_clear_val();

        // 2-4: latency, collisions and read-during-write
        for (int i = 0; i < 10; i++) drive(tbl[i], 1'b1);
        repeat (3) drive(idle, 1'b0);

        // 5: dirty every address, then clear with a second request mid-way
        for (int i = 0; i < DEPTH; i++) shadow[i] = CV;
        shadow[4] = 8'h66; shadow[5] = 8'h3C; shadow[7] = 8'h77;
        shadow[8] = 8'h88; shadow[9] = 8'hFF;
        for (int i = 0; i < DEPTH; i++) begin
            drive(mk(1, 1, 4'(i), 8'(8'h40 + i), 0, 0, 0, 0, 8'(8'h40 + i), shadow[i], 0, 0), 1'b1);
            shadow[i] = 8'(8'h40 + i);
        end
        repeat (2) drive(idle, 1'b0);
        drive(clr, 1'b0);
        repeat (4) drive(idle, 1'b0);
        clr.en_a = 1'b1;
        clr.addr_a = 4'd2;
        drive(clr, 1'b0);
        clr.en_a = 1'b0;
        drive(idle, 1'b0);
        wait_clear_done("req_clear");
        sweep_clear_val();

        // 6: reset in the middle of a clear restarts it
        drive(clr, 1'b0);
        repeat (5) drive(idle, 1'b0);
        do_reset(1);
        wait_clear_done("rst_mid_clear");
        sweep_clear_val();

        repeat (3) drive(idle, 1'b0);
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (exp_q[c].size() != 0) begin
                n_fail++;
                $display("FAIL drain ch%0d: %0d responses outstanding, required 0", c, exp_q[c].size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
